// File: rtl/maga_pkg.sv
// rtl/maga_pkg.sv - shared constants, command table and FSM states for the MAGA poll sequencer
package maga_pkg;

    localparam int         CMD_LEN     = 2;
    localparam logic [1:0] GAP_CYCLES  = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_FAULT   = 2'b10;
    localparam logic [1:0] ERR_NRDY    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_GAP,
        ST_RECV,
        ST_RECV_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_byte = 8'hA5;
            4'd1:    cmd_byte = 8'h01;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/maga_period_timer.sv
// rtl/maga_period_timer.sv - poll period tick generator plus saturating response timeout counter
module maga_period_timer #(
    parameter int POLL_CYCLES    = 1000000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic en,
    input  logic to_clr,
    input  logic to_run,
    output logic tick,
    output logic to_expired
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [PW-1:0] per_q, per_d;
    logic [TW-1:0] to_q, to_d;

    always_comb begin
        per_d = per_q;
        tick  = 1'b0;
        if (!en) begin
            per_d = '0;
        end else if (per_q == PER_LAST) begin
            per_d = '0;
            tick  = 1'b1;
        end else begin
            per_d = per_q + 1'b1;
        end
    end

    // Expiry flags the TIMEOUT_CYCLES-th running cycle; the count parks there.
    always_comb begin
        to_d = to_q;
        if (to_clr) begin
            to_d = '0;
        end else if (to_run && (to_q != TO_LAST)) begin
            to_d = to_q + 1'b1;
        end
    end

    assign to_expired = to_run && (to_q == TO_LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            per_q <= '0;
            to_q  <= '0;
        end else begin
            per_q <= per_d;
            to_q  <= to_d;
        end
    end

endmodule

// File: rtl/maga_poll_seq.sv
// rtl/maga_poll_seq.sv - periodic command/response poller for the MAGA sensor over a UART core
module maga_poll_seq
    import maga_pkg::*;
#(
    parameter int          POLL_CYCLES    = 1000000,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter int          RSP_LEN        = 6,
    parameter logic [12:0] BAUD_VAL       = 13'd325
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        enable,
    input  logic        MAGA_READY,
    input  logic        MAGA_FLT,
    input  logic        TXRDY,
    input  logic        RXRDY,
    input  logic [7:0]  RX,
    output logic [12:0] BAUD_val,
    output logic [7:0]  TX,
    output logic        WEN,
    output logic        OEN,
    output logic        MAGA_EN,
    output logic [7:0]  rsp_byte,
    output logic [3:0]  rsp_idx,
    output logic        rsp_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    localparam logic [3:0] CMD_END = 4'(CMD_LEN);
    localparam logic [3:0] RSP_END = 4'(RSP_LEN);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  gap_q, gap_d;
    logic        en_q;
    logic [7:0]  tx_q, tx_d;
    logic        wen_q, wen_d, oen_q, oen_d;
    logic [7:0]  rsp_byte_q, rsp_byte_d;
    logic [3:0]  rsp_idx_q, rsp_idx_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        tick, to_expired, to_clr, to_run, in_frame;

    maga_period_timer #(
        .POLL_CYCLES    (POLL_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .en         (en_q),
        .to_clr     (to_clr),
        .to_run     (to_run),
        .tick       (tick),
        .to_expired (to_expired)
    );

    assign in_frame = (state_q == ST_SEND) || (state_q == ST_SEND_GAP) ||
                      (state_q == ST_RECV) || (state_q == ST_RECV_GAP);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        tx_d         = tx_q;
        wen_d        = 1'b1;
        oen_d        = 1'b1;
        rsp_byte_d   = rsp_byte_q;
        rsp_idx_d    = rsp_idx_q;
        rsp_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        to_clr       = 1'b0;
        // The response window opens at the last command strobe, not at RECV entry.
        to_run       = (state_q == ST_RECV) || (state_q == ST_RECV_GAP) ||
                       ((state_q == ST_SEND_GAP) && (idx_q == CMD_END));

        if (in_frame && !en_q) begin
            state_d = ST_IDLE;
        end else if (in_frame && MAGA_FLT) begin
            state_d     = ST_ERR;
            err_code_d  = ERR_FAULT;
            frame_err_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gap_d = (gap_q == 2'd0) ? 2'd0 : gap_q - 2'd1;
                    if (tick) begin
                        if (MAGA_FLT) begin
                            state_d     = ST_ERR;
                            err_code_d  = ERR_FAULT;
                            frame_err_d = 1'b1;
                        end else if (!MAGA_READY) begin
                            state_d     = ST_ERR;
                            err_code_d  = ERR_NRDY;
                            frame_err_d = 1'b1;
                        end else begin
                            state_d    = ST_SEND;
                            idx_d      = 4'd0;
                            err_code_d = ERR_NONE;
                        end
                    end else if (RXRDY && (gap_q == 2'd0)) begin
                        oen_d = 1'b0;
                        gap_d = GAP_CYCLES;
                    end
                end
                ST_SEND: begin
                    if (TXRDY) begin
                        tx_d    = cmd_byte(idx_q);
                        wen_d   = 1'b0;
                        idx_d   = idx_q + 4'd1;
                        gap_d   = GAP_CYCLES;
                        state_d = ST_SEND_GAP;
                        to_clr  = (idx_q == CMD_END - 4'd1);
                    end
                end
                ST_SEND_GAP: begin
                    if (gap_q == 2'd1) begin
                        if (idx_q == CMD_END) begin
                            state_d = ST_RECV;
                            idx_d   = 4'd0;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end else begin
                        gap_d = gap_q - 2'd1;
                    end
                end
                ST_RECV: begin
                    if (RXRDY) begin
                        oen_d       = 1'b0;
                        rsp_byte_d  = RX;
                        rsp_idx_d   = idx_q;
                        rsp_valid_d = 1'b1;
                        idx_d       = idx_q + 4'd1;
                        gap_d       = GAP_CYCLES;
                        state_d     = ST_RECV_GAP;
                    end else if (to_expired) begin
                        state_d     = ST_ERR;
                        err_code_d  = ERR_TIMEOUT;
                        frame_err_d = 1'b1;
                    end
                end
                ST_RECV_GAP: begin
                    if ((gap_q == 2'd1) && (idx_q == RSP_END)) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else if (to_expired) begin
                        state_d     = ST_ERR;
                        err_code_d  = ERR_TIMEOUT;
                        frame_err_d = 1'b1;
                    end else if (gap_q == 2'd1) begin
                        state_d = ST_RECV;
                    end else begin
                        gap_d = gap_q - 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            gap_q        <= 2'd0;
            en_q         <= 1'b0;
            tx_q         <= 8'h00;
            wen_q        <= 1'b1;
            oen_q        <= 1'b1;
            rsp_byte_q   <= 8'h00;
            rsp_idx_q    <= 4'd0;
            rsp_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            en_q         <= enable;
            tx_q         <= tx_d;
            wen_q        <= wen_d;
            oen_q        <= oen_d;
            rsp_byte_q   <= rsp_byte_d;
            rsp_idx_q    <= rsp_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign BAUD_val   = BAUD_VAL;
    assign TX         = tx_q;
    assign WEN        = wen_q;
    assign OEN        = oen_q;
    assign MAGA_EN    = en_q;
    assign rsp_byte   = rsp_byte_q;
    assign rsp_idx    = rsp_idx_q;
    assign rsp_valid  = rsp_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;

endmodule
